mult_seq_16x16_ctrl: RTL and testbench

MULT_SEQ_16X16_CTRL -- requirements
Module: mult_seq_16x16_ctrl

---
 rtl/mult_seq_16x16_ctrl.sv | 153 +++++++++++++++
 tb/tb_mult_seq_16x16_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_seq_16x16_ctrl.sv
// Sequential 16x16 signed/unsigned multiplier: one 8x8 Baugh-Wooley core reused over four passes, 5-cycle latency.
// Optional accumulate mode (in_acc port) is enabled by defining MULT_SEQ_ACC_EN.

module mult_bw_8x8 #(
   parameter bit HALF_0 = 1'b0
) (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic        a_sign,
   input  logic        b_sign,
   output logic [15:0] p
);
   logic [15:0] sum;
   logic [15:0] corr;
   logic [15:0] full;
   logic        neg;
   logic        pp;

   // Negative-weight partial products are inverted and their weight subtracted back once.
   always_comb begin
      sum  = '0;
      corr = '0;
      neg  = 1'b0;
      pp   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            neg = ((i == 7) && a_sign) ^ ((j == 7) && b_sign);
            pp  = a[i] & b[j];
            sum = sum + ({15'b0, pp ^ neg} << (i + j));
            if (neg) begin
               corr = corr + (16'd1 << (i + j));
            end
         end
      end
      full = sum - corr;
      p    = HALF_0 ? {8'b0, full[7:0]} : full;
   end
endmodule

module mult_seq_16x16_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic        in_a_sign,
   input  logic        in_b_sign,
`ifdef MULT_SEQ_ACC_EN
   input  logic        in_acc,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_p
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic        sa_r;
   logic        sb_r;
   logic [31:0] acc;

   logic [7:0]  core_a;
   logic [7:0]  core_b;
   logic        core_sa;
   logic        core_sb;
   logic [15:0] core_p;
   logic [31:0] ext;
   logic [31:0] term;

   // cnt[0] selects the high byte of A, cnt[1] the high byte of B.
   always_comb begin
      core_a  = cnt[0] ? a_r[15:8] : a_r[7:0];
      core_b  = cnt[1] ? b_r[15:8] : b_r[7:0];
      core_sa = cnt[0] & sa_r;
      core_sb = cnt[1] & sb_r;
   end

   mult_bw_8x8 #(.HALF_0(1'b0)) u_core (
      .a      (core_a),
      .b      (core_b),
      .a_sign (core_sa),
      .b_sign (core_sb),
      .p      (core_p)
   );

   always_comb begin
      ext = (core_sa | core_sb) ? {{16{core_p[15]}}, core_p} : {16'b0, core_p};
      case (cnt)
         2'd0:    term = ext;
         2'd3:    term = ext << 16;
         default: term = ext << 8;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         acc       <= 32'd0;
         a_r       <= 16'd0;
         b_r       <= 16'd0;
         sa_r      <= 1'b0;
         sb_r      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= in_a;
                  b_r      <= in_b;
                  sa_r     <= in_a_sign;
                  sb_r     <= in_b_sign;
                  cnt      <= 2'd0;
`ifdef MULT_SEQ_ACC_EN
                  acc      <= in_acc ? acc : 32'd0;
`else
                  acc      <= 32'd0;
`endif
                  state    <= MUL;
                  in_ready <= 1'b0;
               end
            end
            MUL: begin
               acc <= acc + term;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_p = acc;
endmodule

// File: tb/tb_mult_seq_16x16_ctrl.sv
// Directed and random checks of mult_seq_16x16_ctrl against an arithmetic reference model.
module tb_mult_seq_16x16_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_a_sign;
   logic        in_b_sign;
   logic        in_acc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_p;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last = 32'd0;

   always #5 clk = ~clk;

   mult_seq_16x16_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_a_sign (in_a_sign),
      .in_b_sign (in_b_sign),
`ifdef MULT_SEQ_ACC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic sa, input logic sb);
      longint va, vb, prod;
      va   = sa ? longint'($signed(a)) : longint'(a);
      vb   = sb ? longint'($signed(b)) : longint'(b);
      prod = va * vb;
      return prod[31:0];
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operation with full handshake/latency checks; hold = cycles out_ready stays low in DONE.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sa, input logic sb, input logic ac,
                         input logic [31:0] exp, input int hold);
      int w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      chk1({tag, "_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; in_a = a; in_b = b; in_a_sign = sa; in_b_sign = sb; in_acc = ac;
      step();
      in_valid = 1'b0;
      in_a = 16'($urandom); in_b = 16'($urandom);
      in_a_sign = 1'($urandom); in_b_sign = 1'($urandom);
      chk1({tag, "_busy"}, in_ready, 1'b0);
      step(); step(); step();
      chk1({tag, "_early"}, out_valid, 1'b0);
      step();
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chk32({tag, "_p"}, out_p, exp);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         in_a = 16'($urandom); in_b = 16'($urandom);
         step();
         chk1({tag, "_hold_valid"}, out_valid, 1'b1);
         chk1({tag, "_hold_ready"}, in_ready, 1'b0);
         chk32({tag, "_hold_p"}, out_p, exp);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk1({tag, "_drop"}, out_valid, 1'b0);
      chk1({tag, "_idle"}, in_ready, 1'b1);
      last = exp;
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rsa, rsb, rac;
      logic [31:0] base;

      reset = 1'b1; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0;
      in_a_sign = 1'b0; in_b_sign = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      chk1("rst_ready", in_ready, 1'b1);
      chk1("rst_valid", out_valid, 1'b0);
      chk32("rst_p", out_p, 32'd0);

      run_op("uns_max", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001, 0);
      run_op("sgn_min", 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'hC0008000, 0);
      run_op("sgn_m1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'h00000001, 0);
      run_op("mixed", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF0001, 0);
      run_op("bp", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 32'h06260060, 10);

      // Reset during the third pass discards the operation.
      in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h9999; in_a_sign = 1'b1; in_b_sign = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      reset = 1'b1;
      in_valid = 1'b1;
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      chk1("midrst_ready", in_ready, 1'b1);
      chk1("midrst_valid", out_valid, 1'b0);
      chk32("midrst_p", out_p, 32'd0);
      last = 32'd0;
      run_op("after_rst", 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 32'h0000000C, 0);

`ifdef MULT_SEQ_ACC_EN
      run_op("acc1", 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 32'h0000000C, 0);
      run_op("acc2", 16'd5, 16'd6, 1'b0, 1'b0, 1'b1, 32'h0000002A, 0);
      run_op("acc3", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 32'h00000029, 0);
`endif

      for (int n = 0; n < 24; n++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rsa = 1'($urandom);
         rsb = 1'($urandom);
         rac = 1'($urandom);
         if (n == 0) begin ra = 16'h8000; rb = 16'h8000; rsa = 1'b1; rsb = 1'b1; end
         if (n == 1) begin ra = 16'h8000; rb = 16'hFFFF; rsa = 1'b1; rsb = 1'b0; end
         if (n == 2) begin ra = 16'h00FF; rb = 16'hFF00; rsa = 1'b0; rsb = 1'b1; end
`ifdef MULT_SEQ_ACC_EN
         base = rac ? last : 32'd0;
`else
         base = 32'd0;
`endif
         run_op("rand", ra, rb, rsa, rsb, rac, base + ref_mul(ra, rb, rsa, rsb), n % 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
